// File: rtl/prm_edge_mask_sched_if.sv
// Obstacle-code input stream and bitmap-word output stream of the PRM edge mask sequencer.
// slave = sequencer view, master = upstream/downstream (testbench or surrounding fabric) view.
interface prm_edge_mask_sched_if #(
    parameter int OBS_W = 15,
    parameter int OUT_W = 32,
    parameter int IDX_W = 4
);
    logic             obs_valid;
    logic             obs_ready;
    logic [OBS_W-1:0] obs_data;
    logic             obs_last;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;

    modport slave (
        input  obs_valid, obs_data, obs_last, out_ready,
        output obs_ready, out_valid, out_data, out_index, out_last
    );

    modport master (
        output obs_valid, obs_data, obs_last, out_ready,
        input  obs_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/prm_edge_mask_sched.sv
// Drives obstacle codes onto the shared edge-checker array, ORs the returned edge masks into a
// blocked-edge bitmap and streams the bitmap out word by word at end of scene.
//
// state   | meaning
// IDLE    | no scene open, accumulator zero, waiting for first code
// LOAD    | scene open, waiting for next code
// EVAL    | checker array settling on chk_code; accumulate chk_mask this cycle
// DRAIN   | emitting bitmap words, one per out handshake
module prm_edge_mask_sched #(
    parameter int NUM_EDGES = 512,
    parameter int OBS_W     = 15,
    parameter int OUT_W     = 32,
    parameter int NUM_WORDS = NUM_EDGES / OUT_W,
    parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    prm_edge_mask_sched_if.slave      bus,
    output logic [OBS_W-1:0]          chk_code,
    input  logic [NUM_EDGES-1:0]      chk_mask,
    output logic [15:0]               scene_words,
    output logic                      busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_EVAL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_EDGES-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OBS_W-1:0]     chk_code_q, chk_code_d;
    logic                 last_q, last_d;
    logic [15:0]          scene_words_q, scene_words_d;

    logic [OUT_W-1:0]     acc_words [NUM_WORDS];
    logic                 in_drain;

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_words
        assign acc_words[w] = acc_q[w*OUT_W +: OUT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            idx_q         <= '0;
            chk_code_q    <= '0;
            last_q        <= 1'b0;
            scene_words_q <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            chk_code_q    <= chk_code_d;
            last_q        <= last_d;
            scene_words_q <= scene_words_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        chk_code_d    = chk_code_q;
        last_d        = last_q;
        scene_words_d = scene_words_q;
        case (state_q)
            S_IDLE: begin
                if (bus.obs_valid) begin
                    chk_code_d    = bus.obs_data;
                    last_d        = bus.obs_last;
                    scene_words_d = 16'd1;
                    state_d       = S_EVAL;
                end
            end
            S_LOAD: begin
                if (bus.obs_valid) begin
                    chk_code_d = bus.obs_data;
                    last_d     = bus.obs_last;
                    if (scene_words_q != 16'hFFFF) begin
                        scene_words_d = scene_words_q + 16'd1;
                    end
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                // chk_code has been stable for the whole cycle, so chk_mask is settled here
                acc_d = acc_q | chk_mask;
                if (last_q) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_drain      = (state_q == S_DRAIN);
    assign bus.obs_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign bus.out_valid = in_drain;
    assign bus.out_data  = in_drain ? acc_words[idx_q] : '0;
    assign bus.out_index = idx_q;
    assign bus.out_last  = in_drain && (idx_q == LAST_IDX);
    assign chk_code      = chk_code_q;
    assign scene_words   = scene_words_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_prm_edge_mask_sched.sv
// Directed bench for prm_edge_mask_sched with a 64-edge one-hot behavioural checker array.
module tb_prm_edge_mask_sched;

    localparam int NUM_EDGES = 64;
    localparam int OBS_W     = 15;
    localparam int OUT_W     = 32;
    localparam int IDX_W     = 1;

    logic                 clk;
    logic                 rst;
    logic [OBS_W-1:0]     chk_code;
    logic [NUM_EDGES-1:0] chk_mask;
    logic [15:0]          scene_words;
    logic                 busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int hs[$];
    logic mon_on = 1'b0;

    prm_edge_mask_sched_if #(.OBS_W(OBS_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

    prm_edge_mask_sched #(
        .NUM_EDGES (NUM_EDGES),
        .OBS_W     (OBS_W),
        .OUT_W     (OUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .chk_code    (chk_code),
        .chk_mask    (chk_mask),
        .scene_words (scene_words),
        .busy        (busy)
    );

    // One-hot checker model: only edge chk_code[5:0] is blocked
    assign chk_mask = 64'd1 << chk_code[5:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_on && bus.obs_valid && bus.obs_ready) hs.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0]        n;
        logic [3:0][14:0]  codes;
        logic [31:0]       w0;
        logic [31:0]       w1;
        logic [15:0]       sw;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out got no event expected handshake", nm);
    endtask

    // Offer one code; returns 1 time unit after the handshake edge (EVAL cycle)
    task automatic send(input logic [14:0] code, input logic last);
        int w;
        w = 0;
        @(negedge clk);
        bus.obs_valid = 1'b1;
        bus.obs_data  = code;
        bus.obs_last  = last;
        while (!bus.obs_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            timeout("send_ready");
            bus.obs_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (last) bus.obs_valid = 1'b0;
            chk("chk_code", 64'(chk_code), 64'(code));
            chk("eval_obs_ready", 64'(bus.obs_ready), 64'd0);
            chk("eval_busy", 64'(busy), 64'd1);
        end
    endtask

    // Accept both bitmap words with out_ready high and check the return to IDLE
    task automatic drain(input logic [31:0] w0, input logic [31:0] w1);
        int w;
        logic [31:0] exp_w;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = 0;
            exp_w = (i == 0) ? w0 : w1;
            while (!bus.out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) begin
                timeout("drain_valid");
                return;
            end
            chk($sformatf("out_data[%0d]", i), 64'(bus.out_data), 64'(exp_w));
            chk($sformatf("out_index[%0d]", i), 64'(bus.out_index), 64'(i));
            chk($sformatf("out_last[%0d]", i), 64'(bus.out_last), (i == 1) ? 64'd1 : 64'd0);
            chk("drain_obs_ready", 64'(bus.obs_ready), 64'd0);
            chk("drain_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_obs_ready", 64'(bus.obs_ready), 64'd1);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{n: 3'd1, codes: {15'd0, 15'd0, 15'd0, 15'd5},
                    w0: 32'h0000_0020, w1: 32'h0000_0000, sw: 16'd1};
        vecs[1] = '{n: 3'd3, codes: {15'd0, 15'd1, 15'd33, 15'd1},
                    w0: 32'h0000_0002, w1: 32'h0000_0002, sw: 16'd3};
        vecs[2] = '{n: 3'd4, codes: {15'd32, 15'd31, 15'd63, 15'd0},
                    w0: 32'h8000_0001, w1: 32'h8000_0001, sw: 16'd4};
        vecs[3] = '{n: 3'd1, codes: {15'd0, 15'd0, 15'd0, 15'h7FC0},
                    w0: 32'h0000_0001, w1: 32'h0000_0000, sw: 16'd1};

        rst           = 1'b1;
        bus.obs_valid = 1'b0;
        bus.obs_data  = '0;
        bus.obs_last  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_obs_ready", 64'(bus.obs_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_index", 64'(bus.out_index), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_scene_words", 64'(scene_words), 64'd0);
        chk("rst_chk_code", 64'(chk_code), 64'd0);
        rst = 1'b0;

        // Single code: out_valid first high one cycle after the EVAL cycle
        send(15'd5, 1'b1);
        chk("lat_eval_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_drain_out_valid", 64'(bus.out_valid), 64'd1);
        drain(32'h0000_0020, 32'h0000_0000);
        chk("t1_scene_words", 64'(scene_words), 64'd1);
        chk("t1_chk_code_held", 64'(chk_code), 64'd5);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                send(vecs[v].codes[k], (k == int'(vecs[v].n) - 1));
            end
            drain(vecs[v].w0, vecs[v].w1);
            chk($sformatf("vec%0d_scene_words", v), 64'(scene_words), 64'(vecs[v].sw));
        end

        // Backpressure on word 0
        bus.out_ready = 1'b0;
        send(15'd40, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_data", 64'(bus.out_data), 64'd0);
            chk("bp_out_index", 64'(bus.out_index), 64'd0);
            chk("bp_out_last", 64'(bus.out_last), 64'd0);
            chk("bp_obs_ready", 64'(bus.obs_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        drain(32'h0000_0000, 32'h0000_0100);

        // Reset in the middle of a scene discards the partial bitmap
        send(15'd7, 1'b0);
        send(15'd9, 1'b0);
        @(negedge clk);
        bus.obs_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_obs_ready", 64'(bus.obs_ready), 64'd1);
        chk("mid_rst_scene_words", 64'(scene_words), 64'd0);
        chk("mid_rst_chk_code", 64'(chk_code), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(15'd0, 1'b1);
        drain(32'h0000_0001, 32'h0000_0000);
        chk("post_rst_scene_words", 64'(scene_words), 64'd1);

        // obs_valid held high: one handshake every second cycle
        mon_on = 1'b1;
        send(15'd10, 1'b0);
        send(15'd11, 1'b0);
        send(15'd12, 1'b0);
        send(15'd13, 1'b1);
        mon_on = 1'b0;
        chk("cont_hs_count", 64'(hs.size()), 64'd4);
        for (int i = 1; i < hs.size(); i++) begin
            chk($sformatf("cont_hs_gap%0d", i), 64'(hs[i] - hs[i-1]), 64'd2);
        end
        drain(32'h0000_3C00, 32'h0000_0000);
        chk("cont_scene_words", 64'(scene_words), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prm_edge_mask_sched.md
# prm_edge_mask_sched

Sequencer for the shared array of PRM obstacle-logic edge checkers (`prm_oblgc_chk*`). Accepts a scene as a stream of 15-bit obstacle codes and drives each code onto the checker array's A..O inputs. ORs the returned per-edge `edge_mask` vector into an accumulated blocked-edge bitmap. At end of scene it streams the bitmap out in fixed-width words to the roadmap/graph-search stage.

## Interface
Parameters:
- `NUM_EDGES`, 512, number of edge checkers in the array; must be a multiple of `OUT_W`.
- `OBS_W`, 15, obstacle code width; bit 0 maps to checker input A, bit 14 to O.
- `OUT_W`, 32, output word width.
- `NUM_WORDS`, derived, equals `NUM_EDGES/OUT_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `obs_valid`  in  1  obstacle code offered.
- `obs_ready`  out  1  block accepts a code.
- `obs_data`  in  OBS_W  obstacle code.
- `obs_last`  in  1  marks the final code of a scene.
- `chk_code`  out  OBS_W  registered code driven to every checker's A..O inputs.
- `chk_mask`  in  NUM_EDGES  checker outputs; bit i is edge i's `edge_mask`.
- `out_valid`  out  1  bitmap word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  OUT_W  bitmap word; bit j is edge `idx*OUT_W+j`.
- `out_index`  out  clog2(NUM_WORDS)  current word index.
- `out_last`  out  1  high with word `NUM_WORDS-1`.
- `scene_words`  out  16  codes accepted in the current/last scene; saturates at 0xFFFF.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, EVAL, DRAIN.
- `obs_ready` = 1 in IDLE and LOAD, 0 in EVAL and DRAIN (decoded from state).
- IDLE: accumulator is zero. On an obs handshake:
  - `chk_code`←`obs_data`
  - `last_r`←`obs_last`
  - `scene_words`←1
  - go to EVAL.
- LOAD: on an obs handshake:
  - `chk_code`←`obs_data`
  - `last_r`←`obs_last`
  - `scene_words`++ (saturating)
  - go to EVAL.
- EVAL (exactly one cycle): `acc`←`acc | chk_mask`. If `last_r`, go to DRAIN with `idx`=0; otherwise go to LOAD.
- DRAIN:
  - `out_valid`=1.
  - `out_data`=`acc[idx*OUT_W +: OUT_W]`, `out_index`=`idx`, `out_last`=(`idx`==NUM_WORDS-1).
  - On an out handshake that is not the last word: `idx`++.
  - On an out handshake of the last word: `acc`←0, `idx`←0, go to IDLE.
- `scene_words` holds its value through DRAIN and IDLE until the next scene's first handshake.
- `chk_code` holds its value after EVAL. It is not cleared on return to IDLE.
- Every scene contains at least one code; no empty scene is possible (`obs_last` is sampled only with a handshake).
- `chk_mask` is sampled only in EVAL; its value in other states is ignored.

## Timing
- Reset (asynchronous, any state): state=IDLE, `acc`=0, `idx`=0, `chk_code`=0, `last_r`=0, `scene_words`=0.
- Output values after reset: `out_valid`=0, `out_last`=0, `out_index`=0, `out_data`=0, `busy`=0, `obs_ready`=1.
- An in-progress scene is discarded by reset; no partial bitmap is emitted.
- Handshake at edge t → `chk_code` updates after t. `chk_mask` must settle combinationally within that cycle; the checker array is single-cycle combinational. Accumulation happens at edge t+1.
- Maximum input throughput: one code per 2 cycles. `obs_ready` is low during EVAL.
- Last code accepted at edge t → `out_valid` is high in the cycle after edge t+1 with word 0.
- Drain takes ≥ NUM_WORDS cycles, one word per out handshake.
- While `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable and `out_valid` stays 1.
- `obs_ready`=0 throughout DRAIN; new-scene codes wait upstream.
- Last-word handshake at edge u → `obs_ready`=1 and `busy`=0 in the cycle after u.

## Test plan
Bench: NUM_EDGES=64, OUT_W=32, behavioural checker model `chk_mask[i] = (i == chk_code[5:0])`.
1. Single-code scene, code 5, `obs_last`=1, `out_ready`=1 → words 0x00000020 then 0x00000000; `out_last` on word 1; `scene_words`=1; `out_valid` first high 2 cycles after the handshake edge.
2. Three-code scene, codes 1, 33, 1 → words 0x00000002, 0x00000002; `scene_words`=3. Duplicate codes do not alter the result.
3. Backpressure: scene with code 40, `out_ready` low for 5 cycles in DRAIN → word 0 = 0x00000000 held stable with `out_valid`=1 and `obs_ready`=0; word 1 = 0x00000100 after release.
4. Reset mid-scene after 2 codes (7, 9), then a new scene with code 0 only → word 0 = 0x00000001 (no stale bits 7/9); `scene_words`=1.
5. `obs_valid` held high continuously with 4 codes → handshakes every 2nd cycle; `obs_ready` low in each EVAL cycle; `busy` high from the first handshake to the last out handshake.
